// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide: shift-add multiply, restoring divide, WIDTH iterations plus one fix-up cycle.
// Result lands 33 edges after start (WIDTH=32); start while busy is dropped; MTHI/MTLO write in one edge from IDLE.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_neg_hi;
  logic               r_neg_lo;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_abs_b  = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Multiply: upper half accumulates the multiplicand, whole register shifts right each step.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_opb};
  assign w_ge       = (w_shift >= {1'b0, r_opb});
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_ge};

  assign w_prod = r_neg_hi ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_state  <= S_CALC;
                r_cnt    <= '0;
                r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                r_opb    <= w_abs_b;
                r_is_div <= op[1];
                if (op[1]) begin
                  // Divide by zero keeps the all-ones quotient the raw iteration yields.
                  r_neg_hi <= w_signed & src_a[WIDTH-1];
                  r_neg_lo <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (|src_b);
                end else begin
                  r_neg_hi <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  r_neg_lo <= 1'b0;
                end
              end
              3'b100:  r_hi <= src_a;
              3'b101:  r_lo <= src_a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed HI/LO results and latency checks.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the done edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inj_mtlo);
    logic [31:0] hi0;
    logic [31:0] lo0;
    bit          stable;
    int          n;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    hi0 = hi; lo0 = lo;
    src_a = ~a; src_b = ~b ^ 32'h5A5A_0001;
    stable = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      if (inj_mtlo && n == 3) begin
        start = 1'b1; op = 3'b101; src_a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!done && (hi !== hi0 || lo !== lo0)) stable = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_stable"}, {63'd0, stable}, 64'd1);
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    bit saw_done;
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load HI/LO, then abort a MULTU mid-calculation with reset.
    start = 1'b1; op = 3'b100; src_a = 32'hAAAA_5555;
    @(posedge clk); #1;
    chk("mthi_hi", {32'd0, hi}, 64'hAAAA_5555);
    chk("mthi_done", {63'd0, done}, 64'd0);
    op = 3'b101; src_a = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    chk("mtlo_lo", {32'd0, lo}, 64'h0F0F_0F0F);
    chk("mtlo_hi", {32'd0, hi}, 64'hAAAA_5555);
    chk("mtlo_done", {63'd0, done}, 64'd0);
    op = 3'b110; src_a = 32'h1234_0000;
    @(posedge clk); #1;
    chk("nop_busy", {63'd0, busy}, 64'd0);
    chk("nop_hi", {32'd0, hi}, 64'hAAAA_5555);
    chk("nop_lo", {32'd0, lo}, 64'h0F0F_0F0F);

    op = 3'b001; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst_no_done", {63'd0, saw_done}, 64'd0);

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_dbz", 3'b011, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op("div_dbz", 3'b010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("div_mtlo", 3'b010, 32'd20, 32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFFD, 1'b1);

    // DIVU then MULTU issued in the DIVU done cycle.
    run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    chk("b2b_done", {63'd0, done}, 64'd1);
    run_op("b2b_multu", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
